// File: rtl/game_hud_timer_if.sv
// VGA pixel bus carried between stages of the video chain.
// master drives the bus; slave observes it.
//   hcount/vcount : pixel position (11 bits each)
//   hsync/vsync   : sync pulses
//   hblnk/vblnk   : blanking flags
//   rgb           : 12-bit colour
interface game_hud_timer_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport master (
      output hcount, vcount, hsync, vsync,
      output hblnk, vblnk, rgb
   );

   modport slave (
      input hcount, vcount, hsync, vsync,
      input hblnk, vblnk, rgb
   );
endinterface

// File: rtl/game_hud_timer.sv
// HUD overlay and round timer: player scores, countdown,
// arena borders, dashed lanes, round end / overtime.
// Ports:
//   clk         : pixel clock
//   rst         : async active-low reset
//   vga_in      : upstream VGA bus (slave)
//   start       : pulse, begins a round from IDLE/DONE
//   pause       : level, freezes the timer in RUN
//   scores      : packed 8-bit scores, player0 in [7:0]
//   vga_out     : overlaid VGA bus, 1-cycle latency
//   timer_value : seconds remaining
//   time_out    : round over, sticky until start/reset
//   leader      : index of top score, lowest wins ties
// Optional macro HUD_FLASH_EN: blink timer digits in the
// last ten seconds and during overtime.
module game_hud_timer #(
   parameter int          NUM_PLAYERS    = 2,
   parameter int          TIMER_START    = 60,
   parameter int          FRAMES_PER_SEC = 60,
   parameter int          HUD_HEIGHT     = 100,
   parameter int          BORDER_W       = 5,
   parameter int          LANE_X0        = 60,
   parameter int          LANE_X1        = 735,
   parameter logic [11:0] FG_COLOR       = 12'hfff
) (
   input  logic                     clk,
   input  logic                     rst,
   game_hud_timer_if.slave          vga_in,
   input  logic                     start,
   input  logic                     pause,
   input  logic [8*NUM_PLAYERS-1:0] scores,
   game_hud_timer_if.master         vga_out,
   output logic [7:0]               timer_value,
   output logic                     time_out,
   output logic [1:0]               leader
);

   localparam int PW = $clog2(FRAMES_PER_SEC);
   localparam logic [PW-1:0] PS_MAX =
      PW'(FRAMES_PER_SEC - 1);
   localparam logic [PW-1:0] PS_HALF =
      PW'(FRAMES_PER_SEC / 2);
   localparam int STEP =
      (NUM_PLAYERS > 1) ? 672 / (NUM_PLAYERS - 1) : 0;
   localparam logic [7:0]  T_START = 8'(TIMER_START);
   localparam logic [10:0] HUD_H   = 11'(HUD_HEIGHT);
   localparam logic [10:0] BW      = 11'(BORDER_W);
   localparam logic [10:0] RIGHT_B = 11'(800 - BORDER_W);
   localparam logic [10:0] LX0     = 11'(LANE_X0);
   localparam logic [10:0] LX1     = 11'(LANE_X1);
   localparam logic [10:0] TIMER_X = 11'd336;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_OVT,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [7:0]    r_timer;
   logic [PW-1:0] r_ps;
   logic          r_tout;
   logic [1:0]    r_leader;
   logic          r_vs_d;

   logic [10:0]   r_hc;
   logic [10:0]   r_vc;
   logic          r_hs;
   logic          r_vs;
   logic          r_hb;
   logic          r_vb;
   logic [11:0]   r_rgb;

   logic          w_tick;
   logic [7:0]    w_max;
   logic [1:0]    w_lead;
   logic          w_tie;
   logic          w_tvis;
   logic          w_digit;
   logic [11:0]   w_rgb;

   // 3x5 glyphs, row-major, MSB is top-left
   function automatic logic [14:0] font(
      input logic [3:0] d
   );
      logic [14:0] g;
      case (d)
         4'd0:    g = 15'b111_101_101_101_111;
         4'd1:    g = 15'b010_110_010_010_111;
         4'd2:    g = 15'b111_001_111_100_111;
         4'd3:    g = 15'b111_001_111_001_111;
         4'd4:    g = 15'b101_101_111_001_001;
         4'd5:    g = 15'b111_100_111_001_111;
         4'd6:    g = 15'b111_100_111_101_111;
         4'd7:    g = 15'b111_001_001_001_001;
         4'd8:    g = 15'b111_101_111_101_111;
         4'd9:    g = 15'b111_101_111_001_111;
         default: g = 15'b0;
      endcase
      return g;
   endfunction

   // Three decimal digits at (xp, 0): glyphs scaled x4
   // (12x20 px) on a 16 px pitch, 48 px total width.
   function automatic logic digit_px(
      input logic [10:0] hc,
      input logic [10:0] vc,
      input logic [10:0] xp,
      input logic [7:0]  val
   );
      logic [10:0] dx;
      logic [7:0]  dv;
      logic [15:0] g;
      logic [3:0]  bi;
      logic        on;
      dx = hc - xp;
      on = (dx < 11'd48) && (vc < 11'd20) &&
           (dx[3:2] != 2'd3);
      case (dx[5:4])
         2'd0:    dv = val / 8'd100;
         2'd1:    dv = (val / 8'd10) % 8'd10;
         default: dv = val % 8'd10;
      endcase
      g  = {1'b0, font(dv[3:0])};
      bi = 4'd14 -
           (4'(vc[4:2]) * 4'd3 + 4'(dx[3:2]));
      return on & g[bi];
   endfunction

   assign w_tick = vga_in.vsync & ~r_vs_d;

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      w_max  = scores[7:0];
      w_lead = 2'd0;
      w_tie  = 1'b0;
      for (int p = 1; p < NUM_PLAYERS; p++) begin
         if (scores[8*p +: 8] > w_max) begin
            w_max  = scores[8*p +: 8];
            w_lead = 2'(p);
            w_tie  = 1'b0;
         end else if (scores[8*p +: 8] == w_max) begin
            w_tie = 1'b1;
         end
      end
   end

`ifdef HUD_FLASH_EN
   always_comb begin
      w_tvis = 1'b1;
      if ((r_state == S_RUN && r_timer <= 8'd10) ||
          r_state == S_OVT)
         w_tvis = (r_ps < PS_HALF);
   end
`else
   assign w_tvis = 1'b1;
`endif

   always_comb begin
      w_digit = 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         w_digit = w_digit | digit_px(
            vga_in.hcount, vga_in.vcount,
            11'(p * STEP), scores[8*p +: 8]);
      end
      w_digit = w_digit | (w_tvis & digit_px(
         vga_in.hcount, vga_in.vcount,
         TIMER_X, r_timer));
   end

   always_comb begin
      w_rgb = vga_in.rgb;
      if (vga_in.hblnk | vga_in.vblnk)
         w_rgb = 12'h000;
      else if (vga_in.vcount >= 11'd595)
         w_rgb = FG_COLOR;
      else if ((vga_in.hcount < BW ||
                vga_in.hcount >= RIGHT_B) &&
               vga_in.vcount > HUD_H)
         w_rgb = FG_COLOR;
      else if (vga_in.vcount >= HUD_H &&
               vga_in.vcount < HUD_H + BW)
         w_rgb = FG_COLOR;
      else if (vga_in.vcount > HUD_H &&
               !vga_in.vcount[3] &&
               ((vga_in.hcount >= LX0 &&
                 vga_in.hcount < LX0 + BW) ||
                (vga_in.hcount >= LX1 &&
                 vga_in.hcount < LX1 + BW)))
         w_rgb = FG_COLOR;
      else if (vga_in.vcount < HUD_H && w_digit)
         w_rgb = FG_COLOR;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_timer  <= T_START;
         r_ps     <= '0;
         r_tout   <= 1'b0;
         r_leader <= 2'd0;
         r_vs_d   <= 1'b0;
      end else begin
         r_leader <= w_lead;
         r_vs_d   <= vga_in.vsync;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_timer <= T_START;
                  r_ps    <= '0;
               end
            end
            S_RUN: begin
               if (r_timer == 8'd0) begin
                  if (w_tie) begin
                     r_state <= S_OVT;
                  end else begin
                     r_state <= S_DONE;
                     r_tout  <= 1'b1;
                  end
               end else if (w_tick && !pause) begin
                  if (r_ps == PS_MAX) begin
                     r_ps    <= '0;
                     r_timer <= r_timer - 8'd1;
                  end else begin
                     r_ps <= r_ps + 1'b1;
                  end
               end
            end
            S_OVT: begin
               // Prescaler keeps cycling so the blink runs.
               if (w_tick)
                  r_ps <= (r_ps == PS_MAX) ?
                          '0 : r_ps + 1'b1;
               if (!w_tie) begin
                  r_state <= S_DONE;
                  r_tout  <= 1'b1;
               end
            end
            S_DONE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_timer <= T_START;
                  r_ps    <= '0;
                  r_tout  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hc  <= '0;
         r_vc  <= '0;
         r_hs  <= 1'b0;
         r_vs  <= 1'b0;
         r_hb  <= 1'b0;
         r_vb  <= 1'b0;
         r_rgb <= '0;
      end else begin
         r_hc  <= vga_in.hcount;
         r_vc  <= vga_in.vcount;
         r_hs  <= vga_in.hsync;
         r_vs  <= vga_in.vsync;
         r_hb  <= vga_in.hblnk;
         r_vb  <= vga_in.vblnk;
         r_rgb <= w_rgb;
      end
   end

   assign vga_out.hcount = r_hc;
   assign vga_out.vcount = r_vc;
   assign vga_out.hsync  = r_hs;
   assign vga_out.vsync  = r_vs;
   assign vga_out.hblnk  = r_hb;
   assign vga_out.vblnk  = r_vb;
   assign vga_out.rgb    = r_rgb;

   assign timer_value = r_timer;
   assign time_out    = r_tout;
   assign leader      = r_leader;

endmodule

// File: tb/tb_game_hud_timer.sv
// Directed bench for game_hud_timer: timer, overtime,
// pause, async reset and pixel overlay priorities.
module tb_game_hud_timer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        pause;
   logic [15:0] scores;
   logic [7:0]  timer_value;
   logic        time_out;
   logic [1:0]  leader;

   int n_chk;
   int n_err;

   localparam logic [11:0] FG = 12'hfff;
   localparam logic [11:0] BG = 12'h123;

   game_hud_timer_if vin ();
   game_hud_timer_if vout ();

   game_hud_timer dut (
      .clk         (clk),
      .rst         (rst),
      .vga_in      (vin),
      .start       (start),
      .pause       (pause),
      .scores      (scores),
      .vga_out     (vout),
      .timer_value (timer_value),
      .time_out    (time_out),
      .leader      (leader)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         vin.vsync = 1'b1;
         @(negedge clk);
         vin.vsync = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic px(
      input string       tag,
      input logic [10:0] h,
      input logic [10:0] v,
      input logic [11:0] exp
   );
      vin.hcount = h;
      vin.vcount = v;
      @(negedge clk);
      check(tag, vout.rgb, exp);
   endtask

   initial begin
      n_chk      = 0;
      n_err      = 0;
      rst        = 1'b0;
      start      = 1'b0;
      pause      = 1'b0;
      scores     = 16'h0503;
      vin.hcount = 11'd200;
      vin.vcount = 11'd50;
      vin.hsync  = 1'b1;
      vin.vsync  = 1'b0;
      vin.hblnk  = 1'b0;
      vin.vblnk  = 1'b0;
      vin.rgb    = BG;
      cyc(3);
      check("rst_timer", timer_value, 60);
      check("rst_tout", time_out, 0);
      check("rst_leader", leader, 0);
      check("rst_rgb", vout.rgb, 0);
      check("rst_hsync", vout.hsync, 0);
      rst = 1'b1;
      cyc(2);
      check("leader_35", leader, 1);

      // Full round with a unique leader
      pulse_start();
      tick(59);
      check("t_59ticks", timer_value, 60);
      tick(1);
      check("t_60ticks", timer_value, 59);
      tick(3539);
      check("t_3599", timer_value, 1);
      check("tout_3599", time_out, 0);
      tick(1);
      cyc(2);
      check("t_3600", timer_value, 0);
      check("done_tout", time_out, 1);
      check("done_leader", leader, 1);

      // Restart from DONE, then async reset at 37
      pulse_start();
      check("restart_tout", time_out, 0);
      check("restart_t", timer_value, 60);
      tick(1380);
      check("t_37", timer_value, 37);
      #2 rst = 1'b0;
      #1;
      check("arst_timer", timer_value, 60);
      check("arst_tout", time_out, 0);
      check("arst_leader", leader, 0);
      check("arst_rgb", vout.rgb, 0);
      @(negedge clk);
      rst = 1'b1;
      cyc(1);
      tick(60);
      check("idle_hold", timer_value, 60);

      // Tie at zero goes to overtime
      scores = 16'h0404;
      pulse_start();
      tick(3600);
      cyc(3);
      check("ovt_timer", timer_value, 0);
      check("ovt_tout", time_out, 0);
      check("ovt_leader", leader, 0);
      pulse_start();
      check("ovt_nostart", timer_value, 0);
      scores = 16'h0504;
      @(negedge clk);
      check("ovt_end_tout", time_out, 1);
      check("ovt_end_lead", leader, 1);

      // Pause freezes timer and prescaler
      pulse_start();
      tick(1800);
      check("t_30", timer_value, 30);
      pause = 1'b1;
      tick(120);
      check("pause_hold", timer_value, 30);
      pause = 1'b0;
      tick(59);
      check("resume_59", timer_value, 30);
      tick(1);
      check("resume_60", timer_value, 29);

      // Pixel overlay, timer shows 029, scores 4 / 5
      vin.hcount = 11'd2;
      vin.vcount = 11'd300;
      vin.hblnk  = 1'b1;
      @(negedge clk);
      check("px_hblnk", vout.rgb, 0);
      vin.hblnk = 1'b0;
      #1;
      check("px_delay", vout.rgb, 0);
      @(negedge clk);
      check("px_border", vout.rgb, FG);
      check("px_hc_dly", vout.hcount, 2);
      check("px_hs_dly", vout.hsync, 1);
      px("px_lane_on", 11'd62, 11'd112, FG);
      px("px_lane_off", 11'd62, 11'd120, BG);
      px("px_lane1", 11'd737, 11'd112, FG);
      px("px_divider", 11'd200, 11'd100, FG);
      px("px_bottom", 11'd200, 11'd597, FG);
      px("px_hud_bg", 11'd200, 11'd50, BG);
      px("px_arena", 11'd400, 11'd300, BG);
      px("px_p0_dig", 11'd0, 11'd0, FG);
      px("px_p1_dig", 11'd704, 11'd0, FG);
      px("px_tmr_gap", 11'd348, 11'd0, BG);
      px("px_tmr_dig", 11'd336, 11'd0, FG);

      // Timer at 10: blink window check
      tick(1140);
      check("t_10", timer_value, 10);
      tick(10);
      px("flash_ps10", 11'd336, 11'd0, FG);
      tick(30);
`ifdef HUD_FLASH_EN
      px("flash_ps40", 11'd336, 11'd0, BG);
`else
      px("flash_ps40", 11'd336, 11'd0, FG);
`endif
      check("t_10_hold", timer_value, 10);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
